// File: rtl/arbiter8_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : arbiter8_rr_if
// Brief    : Request/grant bundle between eight requesters and arbiter8_rr.
// Revision : 1.0
// ============================================================================
interface arbiter8_rr_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       grant_valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_valid,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/arbiter8_rr.sv
`default_nettype none
// ============================================================================
// Module   : arbiter8_rr
// Brief    : Eight-way round-robin arbiter with registered one-hot grant,
//            done/request-drop release and an optional hold-limit timeout.
// Revision : 1.0
// ============================================================================
module arbiter8_rr #(
    parameter int MAX_HOLD = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    arbiter8_rr_if.slave  bus
);

    localparam bit         c_HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] c_HOLD_LAST = 8'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_ptr;
    logic [2:0]  r_owner;
    logic [7:0]  r_hcnt;
    logic [7:0]  r_grant;
    logic        r_grant_valid;
    logic        r_timeout;

    logic        w_win_vld;
    logic [2:0]  w_win_idx;
    logic        w_owner_req;
    logic        w_hold_hit;
    logic        w_exit;

    // Descending scan so the candidate closest to r_ptr is the last one written.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            logic [2:0] cand;
            cand = r_ptr + 3'(k);
            if (bus.req[cand]) begin
                w_win_vld = 1'b1;
                w_win_idx = cand;
            end
        end
    end

    assign w_owner_req = bus.req[r_owner];
    assign w_hold_hit  = c_HOLD_EN && (r_hcnt == c_HOLD_LAST);
    assign w_exit      = bus.done || !w_owner_req || w_hold_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ptr         <= 3'd0;
            r_owner       <= 3'd0;
            r_hcnt        <= 8'd0;
            r_grant       <= 8'd0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if (w_win_vld) begin
                        r_grant       <= 8'd1 << w_win_idx;
                        r_grant_valid <= 1'b1;
                        r_owner       <= w_win_idx;
                        r_hcnt        <= 8'd0;
                        r_state       <= ST_GRANT;
                    end else begin
                        r_state       <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    if (w_exit) begin
                        r_grant       <= 8'd0;
                        r_grant_valid <= 1'b0;
                        r_ptr         <= r_owner + 3'd1;
                        r_state       <= ST_GAP;
                        // done and request drop both outrank the hold limit.
                        r_timeout     <= !bus.done && w_owner_req;
                    end else if (r_hcnt != 8'hFF) begin
                        r_hcnt        <= r_hcnt + 8'd1;
                    end
                end
                default: begin
                    r_grant       <= 8'd0;
                    r_grant_valid <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_valid = r_grant_valid;
    assign bus.timeout     = r_timeout;

    a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(r_grant));
    a_no_direct_switch : assert property (@(posedge clk) disable iff (rst)
        (r_grant != 8'd0) |=> ((r_grant == $past(r_grant)) || (r_grant == 8'd0)));

endmodule
`default_nettype wire

// File: tb/tb_arbiter8_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbiter8_rr
// Brief    : Self-checking bench for arbiter8_rr against an owner/pointer model.
// Revision : 1.0
// ============================================================================
module tb_arbiter8_rr;

    localparam int TB_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arbiter8_rr_if ifm ();
    arbiter8_rr_if if16 ();

    arbiter8_rr #(.MAX_HOLD(TB_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifm)
    );

    arbiter8_rr dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: current owner index (-1 when nobody holds the grant),
    // next search start, cycles already held, and the timeout flag.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_to;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] req, input logic done);
        if (m_owner >= 0) begin
            if (done || !req[m_owner] || (TB_HOLD != 0 && m_held == TB_HOLD - 1)) begin
                m_to    = !done && req[m_owner];
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_to   = 1'b0;
                m_held = (m_held < 255) ? m_held + 1 : 255;
            end
        end else begin
            m_to = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (req[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_held  = 0;
                    break;
                end
            end
        end
    endtask

    function automatic logic [9:0] m_exp();
        logic [7:0] g;
        g = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        return {g, (m_owner >= 0), m_to};
    endfunction

    function automatic int enc8to3(input logic [7:0] g);
        for (int i = 0; i < 8; i++)
            if (g[i]) return i;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge(ifm.req, ifm.done);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifm.req = 8'd0;  ifm.done = 1'b0;
        if16.req = 8'd0; if16.done = 1'b0;
        model_reset();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        rst = 1'b1;
        ifm.done = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            ifm.req = (i % 2 == 0) ? 8'hFF : 8'h00;
            step();
            obs = {ifm.grant, ifm.grant_valid, ifm.timeout};
            n_tests++;
            if (obs !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_hold: got %h expected %h", obs, 10'd0);
            end
        end
        ifm.req = 8'h24;
        rst = 1'b0;
        step();
        obs = {ifm.grant, ifm.grant_valid, ifm.timeout};
        n_tests++;
        if (obs !== {8'h04, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", obs, {8'h04, 1'b1, 1'b0});
        end
    endtask

    task automatic test_round_robin();
        logic [9:0] obs, exp;
        do_reset();
        ifm.req = 8'hFF;
        for (int j = 0; j <= 16; j++) begin
            step();
            exp = (j % 2 == 0) ? {8'd1 << ((j / 2) % 8), 1'b1, 1'b0} : 10'd0;
            obs = {ifm.grant, ifm.grant_valid, ifm.timeout};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: got %h expected %h", j, obs, exp);
            end
            ifm.done = (j % 2 == 0);
        end
        ifm.done = 1'b0;
    endtask

    task automatic test_timeout();
        logic [9:0] obs, exp;
        do_reset();
        ifm.req = 8'h08;
        for (int j = 0; j < 10; j++) begin
            step();
            exp = ((j % 5) < 4) ? {8'h08, 1'b1, 1'b0} : {8'h00, 1'b0, 1'b1};
            obs = {ifm.grant, ifm.grant_valid, ifm.timeout};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL timeout[%0d]: got %h expected %h", j, obs, exp);
            end
        end
    endtask

    task automatic test_drop_collision();
        logic [9:0] obs;
        logic [9:0] exp_seq [10];
        do_reset();
        exp_seq = '{{8'h20, 2'b10}, {8'h20, 2'b10}, 10'd0,          {8'h04, 2'b10},
                    {8'h04, 2'b10}, {8'h04, 2'b10}, {8'h04, 2'b10}, 10'd0,
                    {8'h04, 2'b10}, {8'h04, 2'b10}};
        ifm.req = 8'h20;
        for (int j = 0; j < 10; j++) begin
            step();
            obs = {ifm.grant, ifm.grant_valid, ifm.timeout};
            n_tests++;
            if (obs !== exp_seq[j]) begin
                n_fail++;
                $display("FAIL drop_collision[%0d]: got %h expected %h", j, obs, exp_seq[j]);
            end
            // Owner 5 drops as requester 2 rises; done later lands on the hold-limit edge.
            if (j == 1) ifm.req = 8'h04;
            ifm.done = (j == 6);
        end
        ifm.done = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [9:0] obs;
        do_reset();
        ifm.req = 8'h40;
        step();
        ifm.done = 1'b1;
        step();
        ifm.done = 1'b0;
        step();
        obs = {ifm.grant, ifm.grant_valid, ifm.timeout};
        n_tests++;
        if (obs !== {8'h40, 2'b10}) begin
            n_fail++;
            $display("FAIL async_pre: got %h expected %h", obs, {8'h40, 2'b10});
        end
        #1 rst = 1'b1;
        model_reset();
        #1;
        obs = {ifm.grant, ifm.grant_valid, ifm.timeout};
        n_tests++;
        if (obs !== 10'd0) begin
            n_fail++;
            $display("FAIL async_clear: got %h expected %h", obs, 10'd0);
        end
        #4 rst = 1'b0;
        ifm.req = 8'hC0;
        step();
        obs = {ifm.grant, ifm.grant_valid, ifm.timeout};
        n_tests++;
        if (obs !== {8'h40, 2'b10}) begin
            n_fail++;
            $display("FAIL async_restart: got %h expected %h", obs, {8'h40, 2'b10});
        end
        ifm.req = 8'h00;
    endtask

    task automatic test_hold16();
        logic [9:0] obs, exp;
        do_reset();
        if16.req = 8'h01;
        for (int j = 0; j < 34; j++) begin
            step();
            exp = ((j % 17) < 16) ? {8'h01, 2'b10} : {8'h00, 2'b01};
            obs = {if16.grant, if16.grant_valid, if16.timeout};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL hold16[%0d]: got %h expected %h", j, obs, exp);
            end
        end
        if16.req = 8'h00;
    endtask

    task automatic test_random_encoder();
        logic [9:0] obs, exp;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(3) == 0)
                ifm.req = ($urandom_range(1) == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            ifm.done = ($urandom_range(5) == 0);
            step();
            exp = m_exp();
            obs = {ifm.grant, ifm.grant_valid, ifm.timeout};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", c, obs, exp);
            end
            if (ifm.grant_valid) begin
                n_tests++;
                if (!$onehot(ifm.grant)) begin
                    n_fail++;
                    $display("FAIL enc_onehot[%0d]: got %h expected one-hot", c, ifm.grant);
                end
                n_tests++;
                if (enc8to3(ifm.grant) != m_owner) begin
                    n_fail++;
                    $display("FAIL enc_value[%0d]: got %0d expected %0d", c, enc8to3(ifm.grant), m_owner);
                end
            end
        end
        ifm.req  = 8'h00;
        ifm.done = 1'b0;
    endtask

    initial begin
        ifm.req = 8'h00;  ifm.done = 1'b0;
        if16.req = 8'h00; if16.done = 1'b0;
        #2;
        test_reset();
        test_round_robin();
        test_timeout();
        test_drop_collision();
        test_async_reset();
        test_hold16();
        test_random_encoder();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arbiter8_rr.md
# arbiter8_rr

Eight-requester round-robin arbiter that issues a registered one-hot grant. It sits directly upstream of the 8-to-3 one-hot encoder. `grant` drives the encoder's 8-bit input and `grant_valid` drives its enable, so the encoder only ever sees a clean one-hot code or a disabled input. Grants are held until the owner signals `done`, drops its request, or exceeds a hold limit.

## Interface
- `MAX_HOLD`, default 16: maximum number of cycles one owner may hold the grant. Legal range is 0..255. 0 disables the timeout.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 8: level request per requester. Bit i is requester i.
- `done` input 1: current owner has finished. Sampled only in GRANT.
- `grant` output 8: registered grant. Always one-hot or all-zero.
- `grant_valid` output 1: registered. Equal to the OR of `grant`.
- `timeout` output 1: one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Reset is asynchronous and active-high. While `rst` is high:
  - `grant`=0, `grant_valid`=0, `timeout`=0.
  - State is IDLE, round-robin pointer `ptr`=0, hold counter `hcnt`=0.
  - This takes effect immediately, including mid-grant.
- **Arbitration function.** Pick the first set bit of `req`, searching from `ptr` upward and wrapping 7→0. The result is an index `w`. If `req`=0, there is no winner.
- **States:** IDLE, GRANT, GAP.
- **IDLE** (`grant`=0):
  - If a winner exists: `grant` ← one-hot(`w`), `grant_valid` ← 1, `hcnt` ← 0, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT** (`grant` held constant). Exit conditions are evaluated each edge in this priority order:
  1. `done`=1.
  2. `req[owner]`=0.
  3. `MAX_HOLD`≠0 and `hcnt`=`MAX_HOLD`-1. This exit is a timeout.
- **On any GRANT exit:**
  - `grant` ← 0, `grant_valid` ← 0.
  - `ptr` ← (owner+1) mod 8. Wrap from 7 gives 0.
  - Go to GAP.
  - `timeout` ← 1 only when the exit is caused by condition 3 alone.
- **No exit:** `hcnt` ← `hcnt`+1. `hcnt` is 8-bit and saturates at 255.
- **GAP** (`grant`=0, one cycle):
  - `timeout` ← 0.
  - Arbitrate with the updated `ptr`, exactly as in IDLE. A winner goes to GRANT; no winner goes to IDLE.
- **Invariants:**
  - `grant` never changes from one nonzero value directly to another. At least one all-zero cycle always separates two grants.
  - `grant` never has more than one bit set.
- **Ignored inputs:**
  - `done` is ignored in IDLE and GAP.
  - `req` bits of non-owners are ignored during GRANT.

## Timing
- **Grant latency from IDLE:** `req` set before edge k → `grant` and `grant_valid` visible after edge k.
- **Release:** a condition true before edge m → `grant`=0 after edge m. The earliest next grant is after edge m+1.
- **Single requester held continuously with `MAX_HOLD`=16:**
  - Grant is high for 16 cycles, then 1 gap cycle, then regranted.
  - `timeout` is high during the gap cycle only.
- **Fairness:** with all 8 requesters continuously asserting, grants rotate 0,1,2,…,7,0. Each grant is followed by exactly one gap cycle.
- **Simultaneous `done` and timeout at the same edge:** treated as a `done` release, so `timeout` stays 0.
- **Owner drops `req` in the same cycle that another requester rises:** the release occurs, and the new requester is granted one edge later via GAP.
- **`rst` asserted between edges:** outputs clear without waiting for `clk`. After deassertion, the first arbitration restarts from `ptr`=0.

## Test plan
- **Reset:** hold `rst`=1 while toggling `req`=8'hFF → `grant`=0, `grant_valid`=0, `timeout`=0 throughout. Release reset with `req`=8'h24 → `grant`=8'h04 after the first edge.
- **Round-robin:** `req`=8'hFF, pulse `done` one cycle after each grant → `grant` sequence 01,00,02,00,04,00,…,80,00,01. Check that `ptr` wraps from 7 to 0.
- **Timeout:** `MAX_HOLD`=4, `req`=8'h08 held, `done`=0 → `grant`=8'h08 for 4 cycles, then 0 for 1 cycle with `timeout`=1, then regranted 8'h08.
- **Request drop and done/timeout collision:**
  - Owner 5 drops `req` mid-grant while `req[2]` is set → 1 gap cycle, then `grant`=8'h04.
  - `done` asserted on the timeout cycle → `timeout`=0.
- **Async reset mid-grant:** with `grant`=8'h40, pulse `rst` for half a cycle → `grant` clears before the next edge. After release with `req`=8'hC0, `grant`=8'h40, because `ptr` is back to 0.
- **Encoder pairing:** connect the encoder downstream and randomize `req` for 10k cycles → the encoder input is always one-hot when enabled, and the encoded value equals the index of the set `grant` bit.
